gin_bus_controller: RTL and testbench
=====================================

Name: gin_bus_controller

Overview:
- Sequences one GIN (global input network) segment made of a scan chain of NUM_NODES multicast controllers.
- CONFIG phase: the ID table is shifted serially into the chain via set_id/id_in.
- RUN phase: tagged (tag, value) packets from an upstream producer are forwarded to the chain's shared bus through a one-entry output register, with ready backpressure.
- Sits between the global buffer/scheduler and the GIN root of one PE-array row or column.

Parameters:
- NUM_NODES, 8, multicast controllers in the scan chain (>=2)
- ID_LEN, 4, ID/tag width
- VALUE_LEN, 32, payload width
- CNT_W, 16, width of the sent-packet counter
- Local: AW = $clog2(NUM_NODES), ID-table address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  write ID table entry
- cfg_addr  in  AW  table index = node position (0 = nearest node)
- cfg_id  in  ID_LEN  ID value to write
- cfg_start  in  1  pulse: start scan-chain load
- cfg_busy  out  1  high while in SCAN
- cfg_done  out  1  high while in RUN (chain configured)
- scan_set_id  out  1  drives set_id of every chain node
- scan_id_out  out  ID_LEN  drives id_in of node 0
- pkt_valid  in  1  upstream packet valid
- pkt_ready  out  1  upstream packet accepted when valid&ready
- pkt_tag  in  ID_LEN  destination tag
- pkt_value  in  VALUE_LEN  payload
- gin_enable  out  1  bus valid toward chain
- gin_tag  out  ID_LEN  bus tag
- gin_value  out  VALUE_LEN  bus payload
- gin_ready  in  1  aggregated ready from chain
- pkt_count  out  CNT_W  packets delivered since reset

Behaviour:
- Reset (async, rst=1): state=IDLE; ID table all 0; scan_set_id=0; scan_id_out=0; cfg_busy=0; cfg_done=0; pkt_ready=0; gin_enable=0; gin_tag=0; gin_value=0; pkt_count=0; output register empty.
- Reset asserted mid-SCAN or mid-RUN: same values; a partially shifted chain is not recovered and the packet in the output register is dropped.
- States: IDLE, SCAN, RUN.
- Table writes (cfg_we): accepted in IDLE and RUN, ignored in SCAN. cfg_addr >= NUM_NODES is ignored.
- IDLE -> SCAN on cfg_start.
- RUN -> SCAN on cfg_start only when the output register is empty; otherwise cfg_start is ignored (not queued).
- cfg_start in SCAN is ignored.
- SCAN lasts exactly NUM_NODES cycles, driven by down-counter k = NUM_NODES-1 .. 0:
  - scan_set_id=1.
  - scan_id_out = table[k] (registered output; the farthest node's ID is shifted first).
  - After the last shift cycle: scan_set_id=0 and scan_id_out=0 next cycle; state=RUN.
  - Result: node j holds table[j].
- cfg_busy = (state==SCAN); cfg_done = (state==RUN); both registered.
- Packet path, RUN only:
  - pkt_ready = ~out_valid | gin_ready (combinational); forced 0 outside RUN.
  - On pkt_valid & pkt_ready: gin_tag/gin_value load the packet and out_valid=1 the next cycle.
  - gin_enable = out_valid.
  - A transfer completes in any cycle with gin_enable & gin_ready: pkt_count += 1 (wraps modulo 2^CNT_W).
  - If no new packet loads in that cycle, out_valid clears.
  - Simultaneous complete + accept gives back-to-back packets with no bubble.
  - Latency: packet accepted in cycle t appears on the gin_* outputs in cycle t+1.
- Hold rule: while gin_enable=1 and gin_ready=0, gin_tag and gin_value are stable.
- gin_tag/gin_value keep their last values when idle; they are not zeroed.
- Tags not matching any node are still forwarded; the controller does not filter them.

Test Plan:
- Reset, write table[j]=j+3 for j=0..7, pulse cfg_start -> scan_set_id high for exactly 8 cycles, scan_id_out sequence 10,9,8,7,6,5,4,3, then cfg_done=1; a behavioural chain model holds node j = j+3.
- cfg_we during SCAN (addr 2, id 15) -> table unchanged; a rescan still shifts value 5 for node 2.
- RUN, gin_ready=1, 4 consecutive packets (tag 3, values 0xA0..0xA3) -> gin_enable high 4 consecutive cycles starting one cycle after first accept; pkt_count=4.
- gin_ready=0 for 3 cycles with packet (tag 5, 0xDEAD) held -> gin_tag/gin_value stable, pkt_ready=0, pkt_count unchanged; on gin_ready=1 count +1.
- cfg_start while output register full -> ignored, cfg_done stays 1; cfg_start with register empty -> SCAN, pkt_ready=0 during SCAN.
- Preload pkt_count to 0xFFFF via 65535 sends, then 1 more -> pkt_count=0; assert rst mid-SCAN (cycle 3) -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/gin_bus_controller.sv
// ---------------------------------------------------------------------------
// gin_bus_controller
//   Sequences one GIN segment: a scan chain of NUM_NODES multicast
//   controllers sharing a single tag/value bus.
//
//   CONFIG: an ID table (one entry per chain position) is written through
//   cfg_we/cfg_addr/cfg_id, then cfg_start shifts it into the chain over
//   NUM_NODES cycles. The farthest node's ID goes first, so that after the
//   last shift node j holds table[j].
//   RUN: upstream (tag, value) packets pass through a one-entry output
//   register onto the chain bus with valid/ready backpressure. Every
//   completed bus transfer increments pkt_count.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_id   ID table write port (ignored during SCAN)
//   cfg_start                pulse: start a scan-chain load
//   cfg_busy, cfg_done       state indicators (SCAN / RUN)
//   scan_set_id, scan_id_out scan-chain shift enable and serial ID
//   pkt_valid/ready/tag/value upstream packet handshake
//   gin_enable/tag/value     bus toward the chain, gin_ready from the chain
//   pkt_count                packets delivered since reset (wrapping)
// ---------------------------------------------------------------------------
module gin_bus_controller #(
    parameter int unsigned NUM_NODES = 8,
    parameter int unsigned ID_LEN    = 4,
    parameter int unsigned VALUE_LEN = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    // ID table configuration
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_NODES)-1:0]  cfg_addr,
    input  logic [ID_LEN-1:0]             cfg_id,
    input  logic                          cfg_start,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    // scan chain
    output logic                          scan_set_id,
    output logic [ID_LEN-1:0]             scan_id_out,
    // upstream packets
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    input  logic [ID_LEN-1:0]             pkt_tag,
    input  logic [VALUE_LEN-1:0]          pkt_value,
    // GIN bus
    output logic                          gin_enable,
    output logic [ID_LEN-1:0]             gin_tag,
    output logic [VALUE_LEN-1:0]          gin_value,
    input  logic                          gin_ready,
    // statistics
    output logic [CNT_W-1:0]              pkt_count
);

    localparam int unsigned AW = $clog2(NUM_NODES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Index of the farthest node; the shift sequence starts here.
    localparam logic [AW-1:0] K_LAST = AW'(NUM_NODES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q,       state_d;
    logic [AW-1:0]        k_q,           k_d;
    logic [ID_LEN-1:0]    id_table_q [NUM_NODES];
    logic [ID_LEN-1:0]    id_table_d [NUM_NODES];
    logic                 scan_set_id_q, scan_set_id_d;
    logic [ID_LEN-1:0]    scan_id_out_q, scan_id_out_d;
    logic                 cfg_busy_q,    cfg_busy_d;
    logic                 cfg_done_q,    cfg_done_d;
    logic                 out_valid_q,   out_valid_d;
    logic [ID_LEN-1:0]    gin_tag_q,     gin_tag_d;
    logic [VALUE_LEN-1:0] gin_value_q,   gin_value_d;
    logic [CNT_W-1:0]     pkt_count_q,   pkt_count_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          in_run;
    logic          accept;
    logic          complete;
    logic          addr_ok;
    logic          scan_go;
    logic [AW-1:0] k_dec;

    assign in_run    = (state_q == S_RUN);
    // The output register can take a new packet when empty or draining now.
    assign pkt_ready = in_run & (~out_valid_q | gin_ready);
    assign accept    = pkt_valid & pkt_ready;
    assign complete  = out_valid_q & gin_ready;
    // Widened compare so a non-power-of-two NUM_NODES rejects stray indices.
    assign addr_ok   = ({1'b0, cfg_addr} < (AW+1)'(NUM_NODES));
    // A rescan from RUN is only allowed once the output register is empty,
    // so no packet is on the bus while the chain is being rewritten.
    assign scan_go   = cfg_start &
                       ((state_q == S_IDLE) | ((state_q == S_RUN) & ~out_valid_q));
    assign k_dec     = k_q - AW'(1);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        id_table_d    = id_table_q;
        scan_set_id_d = 1'b0;
        scan_id_out_d = '0;
        out_valid_d   = out_valid_q;
        gin_tag_d     = gin_tag_q;
        gin_value_d   = gin_value_q;
        pkt_count_d   = pkt_count_q;

        // Table writes are frozen while the chain is shifting.
        if (cfg_we && (state_q != S_SCAN) && addr_ok) begin
            id_table_d[cfg_addr] = cfg_id;
        end

        case (state_q)
            S_IDLE, S_RUN: begin
                if (scan_go) begin
                    state_d       = S_SCAN;
                    k_d           = K_LAST;
                    scan_set_id_d = 1'b1;
                    scan_id_out_d = id_table_q[K_LAST];
                end
            end
            S_SCAN: begin
                // k_q is the index currently on scan_id_out.
                if (k_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    k_d           = k_dec;
                    scan_set_id_d = 1'b1;
                    scan_id_out_d = id_table_q[k_dec];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cfg_busy_d = (state_d == S_SCAN);
        cfg_done_d = (state_d == S_RUN);

        // One-entry output register: load on accept, drain on complete.
        if (complete) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end
        out_valid_d = accept | (out_valid_q & ~gin_ready);
        if (accept) begin
            gin_tag_d   = pkt_tag;
            gin_value_d = pkt_value;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            for (int unsigned i = 0; i < NUM_NODES; i++) begin
                id_table_q[i] <= '0;
            end
            scan_set_id_q <= 1'b0;
            scan_id_out_q <= '0;
            cfg_busy_q    <= 1'b0;
            cfg_done_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            gin_tag_q     <= '0;
            gin_value_q   <= '0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            id_table_q    <= id_table_d;
            scan_set_id_q <= scan_set_id_d;
            scan_id_out_q <= scan_id_out_d;
            cfg_busy_q    <= cfg_busy_d;
            cfg_done_q    <= cfg_done_d;
            out_valid_q   <= out_valid_d;
            gin_tag_q     <= gin_tag_d;
            gin_value_q   <= gin_value_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_busy    = cfg_busy_q;
    assign cfg_done    = cfg_done_q;
    assign scan_set_id = scan_set_id_q;
    assign scan_id_out = scan_id_out_q;
    assign gin_enable  = out_valid_q;
    assign gin_tag     = gin_tag_q;
    assign gin_value   = gin_value_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_gin_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_gin_bus_controller
//   Directed bench for gin_bus_controller: ID table scan-in (with a
//   behavioural scan-chain model), packet forwarding with backpressure,
//   rescan gating, counter wrap and asynchronous reset in mid-scan.
//   Forwarded packets are checked against a scoreboard queue filled by the
//   stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gin_bus_controller;

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 4;
    localparam int unsigned VW  = 32;
    localparam int unsigned CW  = 16;

    typedef struct packed {
        logic [IDW-1:0] tag;
        logic [VW-1:0]  value;
    } pkt_t;

    logic           clk;
    logic           rst;
    logic           cfg_we;
    logic [2:0]     cfg_addr;
    logic [IDW-1:0] cfg_id;
    logic           cfg_start;
    logic           cfg_busy;
    logic           cfg_done;
    logic           scan_set_id;
    logic [IDW-1:0] scan_id_out;
    logic           pkt_valid;
    logic           pkt_ready;
    logic [IDW-1:0] pkt_tag;
    logic [VW-1:0]  pkt_value;
    logic           gin_enable;
    logic [IDW-1:0] gin_tag;
    logic [VW-1:0]  gin_value;
    logic           gin_ready;
    logic [CW-1:0]  pkt_count;

    int   n_vec;
    int   n_err;
    pkt_t exp_q[$];
    logic [IDW-1:0] chain [N];

    gin_bus_controller #(
        .NUM_NODES (N),
        .ID_LEN    (IDW),
        .VALUE_LEN (VW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_id      (cfg_id),
        .cfg_start   (cfg_start),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .scan_set_id (scan_set_id),
        .scan_id_out (scan_id_out),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_tag     (pkt_tag),
        .pkt_value   (pkt_value),
        .gin_enable  (gin_enable),
        .gin_tag     (gin_tag),
        .gin_value   (gin_value),
        .gin_ready   (gin_ready),
        .pkt_count   (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural scan chain: node 0 takes id_in, the rest shift outward.
    always @(posedge clk) begin
        if (scan_set_id) begin
            for (int j = N - 1; j > 0; j--) chain[j] <= chain[j-1];
            chain[0] <= scan_id_out;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-side scoreboard: every completed transfer must match the oldest
    // accepted packet.
    always @(negedge clk) begin
        if (!rst && gin_enable && gin_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                pkt_t e;
                e = exp_q.pop_front();
                chk("sb_tag",   64'(gin_tag),   64'(e.tag));
                chk("sb_value", 64'(gin_value), 64'(e.value));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_set_id"},  64'(scan_set_id), 64'd0);
        chk({tag, "_id_out"},  64'(scan_id_out), 64'd0);
        chk({tag, "_busy"},    64'(cfg_busy),    64'd0);
        chk({tag, "_done"},    64'(cfg_done),    64'd0);
        chk({tag, "_pready"},  64'(pkt_ready),   64'd0);
        chk({tag, "_gen"},     64'(gin_enable),  64'd0);
        chk({tag, "_gtag"},    64'(gin_tag),     64'd0);
        chk({tag, "_gvalue"},  64'(gin_value),   64'd0);
        chk({tag, "_count"},   64'(pkt_count),   64'd0);
    endtask

    task automatic write_table();
        for (int j = 0; j < N; j++) begin
            tick();
            cfg_we   = 1'b1;
            cfg_addr = 3'(j);
            cfg_id   = 4'(j + 3);
        end
        tick();
        cfg_we = 1'b0;
    endtask

    // Pulses cfg_start and checks every SCAN cycle; returns at the negedge
    // of the first RUN cycle. table_zero selects all-zero expectations;
    // poke writes table[2]=15 during SCAN; hold_pkt keeps pkt_valid high.
    task automatic do_scan(input string tag, input bit table_zero,
                           input bit poke, input bit hold_pkt);
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        pkt_valid = hold_pkt;
        if (poke) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'd2;
            cfg_id   = 4'd15;
        end
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                tick();
                cfg_we = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_set_id"}, 64'(scan_set_id), 64'd1);
            chk({tag, "_id_out"}, 64'(scan_id_out), table_zero ? 64'd0 : 64'(10 - i));
            chk({tag, "_busy"},   64'(cfg_busy),    64'd1);
            chk({tag, "_pready"}, 64'(pkt_ready),   64'd0);
        end
        tick();
        @(negedge clk);
        chk({tag, "_end_set_id"}, 64'(scan_set_id), 64'd0);
        chk({tag, "_end_id_out"}, 64'(scan_id_out), 64'd0);
        chk({tag, "_end_done"},   64'(cfg_done),    64'd1);
        chk({tag, "_end_busy"},   64'(cfg_busy),    64'd0);
        for (int j = 0; j < N; j++) begin
            chk({tag, "_node"}, 64'(chain[j]), table_zero ? 64'd0 : 64'(j + 3));
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_id = '0; cfg_start = 1'b0;
        pkt_valid = 1'b0; pkt_tag = '0; pkt_value = '0; gin_ready = 1'b0;
        for (int j = 0; j < N; j++) chain[j] = '0;

        // Reset state
        @(negedge clk);
        chk_reset("rst0");
        tick();
        rst = 1'b0;

        // Table load and first scan (with an ignored write during SCAN)
        write_table();
        do_scan("scan1", 1'b0, 1'b1, 1'b0);

        // Four back-to-back packets with gin_ready high
        gin_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            pkt_valid = 1'b1; pkt_tag = 4'd3; pkt_value = 32'hA0 + 32'(i);
            exp_q.push_back('{tag: 4'd3, value: 32'hA0 + 32'(i)});
            @(negedge clk);
            chk("b2b_pready", 64'(pkt_ready), 64'd1);
            chk("b2b_gen",    64'(gin_enable), (i == 0) ? 64'd0 : 64'd1);
        end
        tick();
        pkt_valid = 1'b0;
        @(negedge clk);
        chk("b2b_gen_last", 64'(gin_enable), 64'd1);
        tick();
        @(negedge clk);
        chk("b2b_gen_off", 64'(gin_enable), 64'd0);
        chk("b2b_count",   64'(pkt_count),  64'd4);

        // Backpressure hold
        tick();
        gin_ready = 1'b0;
        pkt_valid = 1'b1; pkt_tag = 4'd5; pkt_value = 32'hDEAD;
        exp_q.push_back('{tag: 4'd5, value: 32'hDEAD});
        @(negedge clk);
        chk("hold_accept_ready", 64'(pkt_ready), 64'd1);
        tick();
        pkt_tag = 4'd6; pkt_value = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("hold_gen",    64'(gin_enable), 64'd1);
            chk("hold_tag",    64'(gin_tag),    64'd5);
            chk("hold_value",  64'(gin_value),  64'hDEAD);
            chk("hold_pready", 64'(pkt_ready),  64'd0);
            chk("hold_count",  64'(pkt_count),  64'd4);
        end
        tick();
        gin_ready = 1'b1;
        exp_q.push_back('{tag: 4'd6, value: 32'hBEEF});
        @(negedge clk);
        chk("release_pready", 64'(pkt_ready), 64'd1);

        // cfg_start with the output register full is dropped
        tick();
        pkt_valid = 1'b0; gin_ready = 1'b0; cfg_start = 1'b1;
        @(negedge clk);
        chk("release_count", 64'(pkt_count), 64'd5);
        chk("b2b_next_tag",  64'(gin_tag),   64'd6);
        tick();
        cfg_start = 1'b0; gin_ready = 1'b1;
        @(negedge clk);
        chk("full_start_done",   64'(cfg_done),    64'd1);
        chk("full_start_busy",   64'(cfg_busy),    64'd0);
        chk("full_start_set_id", 64'(scan_set_id), 64'd0);
        chk("full_start_gen",    64'(gin_enable),  64'd1);
        tick();
        @(negedge clk);
        chk("drain_gen",   64'(gin_enable), 64'd0);
        chk("drain_count", 64'(pkt_count),  64'd6);

        // Rescan from RUN with the register empty; packet held off in SCAN
        pkt_tag = 4'd1; pkt_value = 32'h11;
        do_scan("scan2", 1'b0, 1'b0, 1'b1);
        exp_q.push_back('{tag: 4'd1, value: 32'h11});
        tick();
        pkt_valid = 1'b0;
        @(negedge clk);
        chk("post_scan_gen", 64'(gin_enable), 64'd1);
        tick();
        @(negedge clk);
        chk("post_scan_count", 64'(pkt_count), 64'd7);

        // Reset, then counter wrap
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst1");
        tick();
        rst = 1'b0;
        do_scan("scan3", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            tick();
            pkt_valid = 1'b1; pkt_tag = 4'(i); pkt_value = 32'(i);
            exp_q.push_back('{tag: 4'(i), value: 32'(i)});
        end
        tick();
        pkt_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("wrap_pre_count", 64'(pkt_count), 64'hFFFF);
        tick();
        pkt_valid = 1'b1; pkt_tag = 4'd7; pkt_value = 32'h1234;
        exp_q.push_back('{tag: 4'd7, value: 32'h1234});
        tick();
        pkt_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("wrap_count",    64'(pkt_count),  64'd0);
        chk("idle_gen",      64'(gin_enable), 64'd0);
        chk("idle_tag_kept", 64'(gin_tag),    64'd7);
        chk("idle_val_kept", 64'(gin_value),  64'h1234);

        // Asynchronous reset in the fourth SCAN cycle
        write_table();
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("mid_scan_id_out", 64'(scan_id_out), 64'd7);
        chk("mid_scan_busy",   64'(cfg_busy),    64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_release");

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
